// File: rtl/bitstream_fetch_ctrl.sv
// Bitstream fetch controller: byte-fed MSB-aligned bit buffer that serves
// variable-length (1..9 bit) read requests, byte-align flushes and
// end-of-stream zero padding for a downstream decoder.
module bitstream_fetch_ctrl #(
  parameter int BUF_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_req,
  input  logic        bits_req,
  input  logic [3:0]  bits_num,
  input  logic        flush,
  output logic        bits_busy,
  output logic        bits_ack,
  output logic [8:0]  bits_data,
  output logic        eos,
  output logic [31:0] total_bits
);

  localparam int CW = $clog2(BUF_W + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d, buf_sh, byte_ext;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_rem, consume;
  logic [3:0]        n_q, n_d, add;
  logic              got_q;
  logic              ack_d, eos_d, drain;
  logic [8:0]        data_d, top9;

  // Refill whenever a whole byte fits; nothing more is taken after end-of-stream.
  assign byte_req  = byte_valid & (cnt_q <= CW'(BUF_W - 8)) & ~eos;
  assign bits_busy = (state_q == S_WAIT);
  assign top9      = buf_q[BUF_W-1 -: 9];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus how many leading bits leave the buffer this edge.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    consume = '0;
    add     = '0;
    ack_d   = 1'b0;
    data_d  = bits_data;
    eos_d   = eos;
    drain   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // Drop the partial byte so the next read starts byte-aligned.
          consume = CW'(cnt_q[2:0]);
          add     = {1'b0, cnt_q[2:0]};
        end else if (bits_req) begin
          // Illegal lengths degrade to an empty read that still acks.
          n_d     = (bits_num == 4'd0 || bits_num > 4'd9) ? 4'd0 : bits_num;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q >= CW'(n_q)) begin
          consume = CW'(n_q);
          add     = n_q;
          data_d  = top9 >> (4'd9 - n_q);
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else if (eos || (!byte_valid && got_q)) begin
          // Source dried up: hand out what is left, zero padded (bits below
          // cnt are always zero), and latch end-of-stream.
          drain   = 1'b1;
          add     = n_q;
          data_d  = top9 >> (4'd9 - n_q);
          ack_d   = 1'b1;
          eos_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift out consumed bits, then drop a fresh byte just below what remains.
  always_comb begin
    cnt_rem  = drain ? '0 : cnt_q - consume;
    buf_sh   = drain ? '0 : buf_q << consume;
    byte_ext = {byte_data, {(BUF_W-8){1'b0}}} >> cnt_rem;
    buf_d    = buf_sh | (byte_req ? byte_ext : '0);
    cnt_d    = cnt_rem + (byte_req ? CW'(8) : CW'(0));
  end

  // Datapath and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      got_q      <= 1'b0;
      bits_ack   <= 1'b0;
      bits_data  <= '0;
      eos        <= 1'b0;
      total_bits <= '0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      got_q      <= got_q | byte_req;
      bits_ack   <= ack_d;
      bits_data  <= data_d;
      eos        <= eos_d;
      total_bits <= total_bits + 32'(add);
    end
  end

endmodule

// File: doc/bitstream_fetch_ctrl.md
BITSTREAM_FETCH_CTRL -- requirements
Module: bitstream_fetch_ctrl

Interface
REQ-001 SHALL have parameter BUF_W, default 24, bit-buffer width in bits; legal range 16..32, multiple of 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port byte_data  input  8  current byte from byte source; meaningful while byte_valid=1.
REQ-005 SHALL have port byte_valid  input  1  byte source holds an unconsumed byte.
REQ-006 SHALL have port byte_req  output  1  byte consume strobe; byte_data captured at the edge where byte_req=1; source presents next byte (or drops byte_valid) after that edge.
REQ-007 SHALL have port bits_req  input  1  decoder request strobe, sampled only when bits_busy=0.
REQ-008 SHALL have port bits_num  input  4  requested bit count, 1..9, sampled with bits_req.
REQ-009 SHALL have port flush  input  1  byte-align strobe, sampled only when bits_busy=0.
REQ-010 SHALL have port bits_busy  output  1  request pending (state WAIT).
REQ-011 SHALL have port bits_ack  output  1  one-cycle response pulse, registered.
REQ-012 SHALL have port bits_data  output  9  response bits, right-aligned, first stream bit at MSB of the n-bit field, upper bits 0.
REQ-013 SHALL have port eos  output  1  sticky end-of-stream flag.
REQ-014 SHALL have port total_bits  output  32  count of bits delivered or discarded since reset, wrapping mod 2^32.

Function
REQ-015 SHALL keep an MSB-aligned shift buffer of BUF_W bits with fill count cnt (0..BUF_W).
REQ-016 SHALL drive byte_req combinationally = byte_valid & (cnt <= BUF_W-8) & ~eos.
REQ-017 SHALL, at a byte_req edge, append byte_data immediately below the bits remaining after any same-edge consumption; cnt_next = cnt - consumed + 8.
REQ-018 SHALL support back-to-back byte_req on consecutive cycles.
REQ-019 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-020 IDLE: flush=1 -> discard (cnt mod 8) leading bits, total_bits += discarded, stay IDLE; flush has priority, simultaneous bits_req is dropped and never acked.
REQ-021 IDLE: bits_req=1, flush=0 -> latch n=bits_num, go WAIT.
REQ-022 WAIT: cnt >= n -> at that edge remove n leading bits, register them into bits_data, bits_ack=1 next cycle, total_bits += n, go IDLE.
REQ-023 WAIT: cnt < n, byte_valid=0, and at least one byte accepted since reset -> deliver the cnt available bits followed by zero padding, cnt=0, total_bits += n, eos=1, bits_ack=1 next cycle, go IDLE.
REQ-024 WAIT: cnt < n otherwise -> stay WAIT, no ack, refill continues.
REQ-025 bits_num=0 or >9 -> treated as n=0: ack with bits_data=0 one cycle after WAIT entry; cnt and total_bits unchanged.
REQ-026 Minimum latency: bits_req accepted at edge k, data removed at edge k+1, bits_ack high during the cycle after edge k+1.
REQ-027 bits_data SHALL hold its value until the next ack; bits_ack is exactly one cycle wide.
REQ-028 eos SHALL remain 1 until reset; further requests are acked with zero bits.

Reset
REQ-029 rst_n=0 SHALL immediately clear buffer, cnt, total_bits, bits_data, bits_ack, eos, the accepted-byte flag; state -> IDLE.
REQ-030 Reset mid-WAIT SHALL abandon the request with no ack; bits_req held high across deassertion is sampled only at the first edge with rst_n=1.

Verification
REQ-031 Stream A5,3C,0F,...; request n=9 -> bits_data=0x14A, one ack, total_bits=9; byte_req pulses until cnt>16.
REQ-032 Continue: request n=1 -> bits_data=0x000, total_bits=10.
REQ-033 Continue: flush -> 6 bits discarded, total_bits=16; request n=8 -> bits_data=0x0F, total_bits=24.
REQ-034 Stream FF only, byte_valid then low; request n=9 -> bits_data=0x1FE, eos=1, ack; next request n=4 -> 0x000.
REQ-035 rst_n low while in WAIT with insufficient bits -> all outputs 0, no ack after release.
REQ-036 bits_num=0 -> ack with 0x000 two cycles after bits_req; total_bits unchanged; flush and bits_req on the same cycle -> flush only, no ack.
